// File: rtl/up2_pkg.sv
// Shared definitions for the UP2 stopwatch: FSM states, BCD digit type,
// button indices and the active-low seven-segment decode.
package up2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_LAP  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int BT_START = 0;
    localparam int BT_LAP   = 1;
    localparam int BT_CLEAR = 2;

    // Segment order is [6]=a .. [0]=g, a lit segment is driven low.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg7(input bcd_t d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/up2_debounce.sv
// One push-button conditioner: two-flop synchroniser, stable-level counter,
// and a single-cycle pulse when a press (1->0) is accepted.
module up2_debounce #(
    parameter int DEB_CYCLES = 250_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic press_o
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q, stable_q, press_q;
    logic [CW-1:0] cnt_q;

    // A new level is taken only after it differs from the accepted one for DEB_CYCLES cycles.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q <= btn_ni;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
                press_q  <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/up2_stopwatch.sv
// Centisecond stopwatch core: button conditioning, start/stop/lap/clear FSM,
// SS.cc BCD count with prescaler, lap snapshot and registered 7-seg outputs.
module up2_stopwatch
    import up2_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int TICK_HZ    = 100,
    parameter int DEB_CYCLES = 250_000
) (
    input  logic       MCLK,
    input  logic       RST_N,
    input  logic [3:0] BT,
    output logic [6:0] DISP1,
    output logic [6:0] DISP2,
    output logic [6:0] DISP3,
    output logic [6:0] DISP4,
    output logic       DISP1_DP,
    output logic       DISP2_DP,
    output logic       DISP3_DP,
    output logic       DISP4_DP,
    output logic       RUNNING,
    output logic       FROZEN,
    output logic       OVERFLOW
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic              pressStart, pressLap, pressClear;
    logic              startEv, lapEv, clearEv;
    logic              unused_bt3;
    state_t            state_q;
    logic [PW-1:0]     presc_q, presc_d;
    bcd_t [3:0]        count_q, count_d, snap_q, shown;
    logic [3:0][6:0]   seg_q;
    logic              running, tick, wrap, carry;
    logic              running_q, frozen_q, overflow_q;

    up2_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk_i(MCLK), .rst_ni(RST_N), .btn_ni(BT[BT_START]), .press_o(pressStart)
    );
    up2_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
        .clk_i(MCLK), .rst_ni(RST_N), .btn_ni(BT[BT_LAP]), .press_o(pressLap)
    );
    up2_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .clk_i(MCLK), .rst_ni(RST_N), .btn_ni(BT[BT_CLEAR]), .press_o(pressClear)
    );

    assign unused_bt3 = BT[3];

    // Clear outranks start/stop, which outranks lap; losers in the same cycle are discarded.
    assign clearEv = pressClear;
    assign startEv = pressStart & ~pressClear;
    assign lapEv   = pressLap & ~pressStart & ~pressClear;

    assign running = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign tick    = running && (presc_q == PRESC_LAST);
    assign shown   = (state_q == ST_LAP) ? snap_q : count_q;

    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        carry   = 1'b0;
        wrap    = 1'b0;
        if (state_q == ST_IDLE || tick) begin
            presc_d = '0;
        end else if (running) begin
            presc_d = presc_q + PW'(1);
        end
        // Ripple carry through the digits; a carry out of the top digit is the wrap.
        if (tick) begin
            carry = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (count_q[i] >= 4'd9) begin
                        count_d[i] = 4'd0;
                    end else begin
                        count_d[i] = count_q[i] + 4'd1;
                        carry      = 1'b0;
                    end
                end
            end
            wrap = carry;
        end
        if (state_q == ST_STOP && clearEv) begin
            count_d = '0;
            presc_d = '0;
        end
    end

    always_ff @(posedge MCLK) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            count_q    <= '0;
            snap_q     <= '0;
            seg_q      <= {4{SEG_0}};
            running_q  <= 1'b0;
            frozen_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            running_q <= running;
            frozen_q  <= (state_q == ST_LAP);
            if (wrap) begin
                overflow_q <= 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                seg_q[i] <= seg7(shown[i]);
            end
            case (state_q)
                ST_IDLE: if (startEv) state_q <= ST_RUN;
                ST_RUN: begin
                    if (startEv) begin
                        state_q <= ST_STOP;
                    end else if (lapEv) begin
                        state_q <= ST_LAP;
                        snap_q  <= count_q;
                    end
                end
                ST_LAP: begin
                    if (startEv) begin
                        state_q <= ST_STOP;
                    end else if (lapEv) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_STOP: begin
                    if (clearEv) begin
                        state_q    <= ST_IDLE;
                        overflow_q <= 1'b0;
                    end else if (startEv) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign DISP1    = seg_q[3];
    assign DISP2    = seg_q[2];
    assign DISP3    = seg_q[1];
    assign DISP4    = seg_q[0];
    assign DISP1_DP = 1'b1;
    assign DISP2_DP = 1'b0;
    assign DISP3_DP = 1'b1;
    assign DISP4_DP = 1'b1;
    assign RUNNING  = running_q;
    assign FROZEN   = frozen_q;
    assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_up2_stopwatch.sv
// Directed bench for up2_stopwatch: one fast-debounce instance at 10 cycles per tick,
// and a second at 1 cycle per tick so the 99.99 wrap is reachable quickly.
module tb_up2_stopwatch;

    logic       clk = 1'b0;
    logic       rstN1, rstN2;
    logic [3:0] bt1, bt2;
    logic [6:0] d1a, d2a, d3a, d4a, d1b, d2b, d3b, d4b;
    logic       dp1a, dp2a, dp3a, dp4a, dp1b, dp2b, dp3b, dp4b;
    logic       run1, frz1, ovf1, run2, frz2, ovf2;
    int         checks = 0;
    int         errors = 0;
    int         pos = 0;

    logic [6:0] segLut [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    always #5 clk = ~clk;

    up2_stopwatch #(.CLK_HZ(1000), .TICK_HZ(100), .DEB_CYCLES(4)) dut (
        .MCLK(clk), .RST_N(rstN1), .BT(bt1),
        .DISP1(d1a), .DISP2(d2a), .DISP3(d3a), .DISP4(d4a),
        .DISP1_DP(dp1a), .DISP2_DP(dp2a), .DISP3_DP(dp3a), .DISP4_DP(dp4a),
        .RUNNING(run1), .FROZEN(frz1), .OVERFLOW(ovf1)
    );

    up2_stopwatch #(.CLK_HZ(100), .TICK_HZ(100), .DEB_CYCLES(4)) dutWrap (
        .MCLK(clk), .RST_N(rstN2), .BT(bt2),
        .DISP1(d1b), .DISP2(d2b), .DISP3(d3b), .DISP4(d4b),
        .DISP1_DP(dp1b), .DISP2_DP(dp2b), .DISP3_DP(dp3b), .DISP4_DP(dp4b),
        .RUNNING(run2), .FROZEN(frz2), .OVERFLOW(ovf2)
    );

    // Expected four-digit pattern for a reading given as an integer SScc.
    function automatic logic [27:0] dispOf(input int v);
        return {segLut[(v / 1000) % 10], segLut[(v / 100) % 10], segLut[(v / 10) % 10], segLut[v % 10]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit second, input logic [3:0] pressMask);
        if (second) bt2 = ~pressMask;
        else        bt1 = ~pressMask;
    endtask

    task automatic stepTo(input int target);
        while (pos < target) begin
            @(negedge clk);
            pos++;
        end
    endtask

    // Position 0 becomes the first falling edge at which RUNNING shows the new level.
    task automatic waitRunning(input bit second, input logic level, input string tag);
        int n;
        n = 0;
        while ((second ? run2 : run1) !== level && n < 60) begin
            @(negedge clk);
            n++;
        end
        pos = 0;
        checkOutput(tag, {31'd0, (second ? run2 : run1)}, {31'd0, level});
    endtask

    task automatic resetDut1();
        rstN1 = 1'b0;
        repeat (3) @(negedge clk);
        rstN1 = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bt1   = 4'hF;
        bt2   = 4'hF;
        rstN1 = 1'b0;
        rstN2 = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_disp", {d1a, d2a, d3a, d4a}, dispOf(0));
        checkOutput("rst_dp", {dp1a, dp2a, dp3a, dp4a}, 4'b1011);
        checkOutput("rst_running", run1, 0);
        checkOutput("rst_frozen", frz1, 0);
        checkOutput("rst_overflow", ovf1, 0);
        checkOutput("rst2_disp", {d1b, d2b, d3b, d4b}, dispOf(0));
        checkOutput("rst2_dp", {dp1b, dp2b, dp3b, dp4b}, 4'b1011);
        checkOutput("rst2_frozen", frz2, 0);
        rstN1 = 1'b1;
        @(negedge clk);

        $display("[TB] bouncing start button");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, (i % 2 == 0) ? 4'b0001 : 4'b0000);
            repeat (2) @(negedge clk);
        end
        checkOutput("bounce_idle", run1, 0);
        applyStimulus(0, 4'b0001);
        waitRunning(0, 1'b1, "bounce_start");
        stepTo(30);
        applyStimulus(0, 4'b0000);
        stepTo(2505);
        checkOutput("run_0250", {d1a, d2a, d3a, d4a}, dispOf(250));
        checkOutput("run_single_pulse", run1, 1);

        $display("[TB] lap freeze and release");
        resetDut1();
        applyStimulus(0, 4'b0001);
        waitRunning(0, 1'b1, "lap_start");
        stepTo(20);
        applyStimulus(0, 4'b0000);
        stepTo(1228);
        applyStimulus(0, 4'b0010);
        stepTo(1238);
        applyStimulus(0, 4'b0000);
        stepTo(1260);
        checkOutput("lap_frozen", frz1, 1);
        checkOutput("lap_disp_0123", {d1a, d2a, d3a, d4a}, dispOf(123));
        stepTo(2990);
        checkOutput("lap_held_0123", {d1a, d2a, d3a, d4a}, dispOf(123));
        stepTo(2995);
        applyStimulus(0, 4'b0010);
        stepTo(3005);
        applyStimulus(0, 4'b0000);
        stepTo(3006);
        checkOutput("unlap_disp_0300", {d1a, d2a, d3a, d4a}, dispOf(300));
        checkOutput("unlap_frozen", frz1, 0);

        $display("[TB] stop, resume, clear");
        resetDut1();
        applyStimulus(0, 4'b0001);
        waitRunning(0, 1'b1, "sr_start");
        stepTo(20);
        applyStimulus(0, 4'b0000);
        stepTo(200);
        applyStimulus(0, 4'b0100);
        stepTo(210);
        applyStimulus(0, 4'b0000);
        stepTo(235);
        checkOutput("clear_in_run_running", run1, 1);
        checkOutput("clear_in_run_disp", {d1a, d2a, d3a, d4a}, dispOf(23));
        stepTo(568);
        applyStimulus(0, 4'b0001);
        stepTo(578);
        applyStimulus(0, 4'b0000);
        stepTo(600);
        checkOutput("stop_running", run1, 0);
        checkOutput("stop_disp_0057", {d1a, d2a, d3a, d4a}, dispOf(57));
        stepTo(700);
        applyStimulus(0, 4'b0001);
        waitRunning(0, 1'b1, "resume");
        stepTo(6);
        checkOutput("resume_partial_0058", {d1a, d2a, d3a, d4a}, dispOf(58));
        stepTo(12);
        checkOutput("resume_hold_0058", {d1a, d2a, d3a, d4a}, dispOf(58));
        stepTo(16);
        checkOutput("resume_next_0059", {d1a, d2a, d3a, d4a}, dispOf(59));
        stepTo(20);
        applyStimulus(0, 4'b0000);
        stepTo(40);
        applyStimulus(0, 4'b0001);
        waitRunning(0, 1'b0, "stop_again");
        stepTo(20);
        applyStimulus(0, 4'b0000);
        stepTo(30);
        applyStimulus(0, 4'b0100);
        stepTo(40);
        applyStimulus(0, 4'b0000);
        stepTo(60);
        checkOutput("clear_disp", {d1a, d2a, d3a, d4a}, dispOf(0));
        checkOutput("clear_running", run1, 0);

        $display("[TB] wrap at 99.99");
        rstN2 = 1'b1;
        @(negedge clk);
        applyStimulus(1, 4'b0001);
        waitRunning(1, 1'b1, "wrap_start");
        stepTo(20);
        applyStimulus(1, 4'b0000);
        stepTo(9995);
        checkOutput("wrap_pre_disp", {d1b, d2b, d3b, d4b}, dispOf(9995));
        checkOutput("wrap_pre_ovf", ovf2, 0);
        stepTo(10003);
        checkOutput("wrap_post_disp", {d1b, d2b, d3b, d4b}, dispOf(3));
        checkOutput("wrap_post_ovf", ovf2, 1);
        stepTo(10500);
        checkOutput("wrap_sticky_ovf", ovf2, 1);
        checkOutput("wrap_sticky_disp", {d1b, d2b, d3b, d4b}, dispOf(500));
        applyStimulus(1, 4'b0001);
        waitRunning(1, 1'b0, "wrap_stop");
        stepTo(20);
        applyStimulus(1, 4'b0000);
        stepTo(30);
        applyStimulus(1, 4'b0100);
        stepTo(40);
        applyStimulus(1, 4'b0000);
        stepTo(60);
        checkOutput("wrap_clear_ovf", ovf2, 0);
        checkOutput("wrap_clear_disp", {d1b, d2b, d3b, d4b}, dispOf(0));

        $display("[TB] simultaneous presses and reset mid-run");
        resetDut1();
        applyStimulus(0, 4'b0001);
        waitRunning(0, 1'b1, "sim_start");
        stepTo(20);
        applyStimulus(0, 4'b0000);
        stepTo(100);
        applyStimulus(0, 4'b0001);
        waitRunning(0, 1'b0, "sim_stop");
        stepTo(20);
        applyStimulus(0, 4'b0000);
        stepTo(30);
        applyStimulus(0, 4'b0101);
        stepTo(40);
        applyStimulus(0, 4'b0000);
        stepTo(60);
        checkOutput("start_clear_running", run1, 0);
        checkOutput("start_clear_disp", {d1a, d2a, d3a, d4a}, dispOf(0));
        stepTo(100);
        applyStimulus(0, 4'b0001);
        waitRunning(0, 1'b1, "sim_restart");
        stepTo(20);
        applyStimulus(0, 4'b0000);
        stepTo(50);
        applyStimulus(0, 4'b0011);
        waitRunning(0, 1'b0, "start_lap_stop");
        stepTo(20);
        applyStimulus(0, 4'b0000);
        stepTo(30);
        checkOutput("start_lap_frozen", frz1, 0);
        stepTo(40);
        applyStimulus(0, 4'b0001);
        waitRunning(0, 1'b1, "pre_reset_run");
        stepTo(20);
        applyStimulus(0, 4'b0000);
        stepTo(100);
        rstN1 = 1'b0;
        @(negedge clk);
        checkOutput("midrun_rst_disp", {d1a, d2a, d3a, d4a}, dispOf(0));
        checkOutput("midrun_rst_dp", {dp1a, dp2a, dp3a, dp4a}, 4'b1011);
        checkOutput("midrun_rst_running", run1, 0);
        checkOutput("midrun_rst_frozen", frz1, 0);
        checkOutput("midrun_rst_overflow", ovf1, 0);
        rstN1 = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
